branch_resolve_ctrl: RTL and testbench

//  Sequences branch resolution in ID around the combinational branch unit.
//  - Holds a branch in ID until the operands it needs are ready.
//  - Releases it to EX and samples the unit's mispredict result (next PC, cancel).
//  - On a mispredict, drives a held redirect to IF, then squashes the wrong path
//    for a fixed number of cycles.
//  - Keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for ID: holds unresolvable branches, releases
// them to EX, and on a mispredict drives a held redirect then flushes IF/ID.
module branch_resolve_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_WD       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_need_src1,
    input  logic              id_need_src2,
    input  logic              src_1_ready,
    input  logic              src_2_ready,
    input  logic [31:0]       bu_next_pc,
    input  logic              bu_cancel,
    input  logic              ex_allowin,
    input  logic              fetch_ready,
    output logic              id_stall,
    output logic              id_to_ex_valid,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              flush_if,
    output logic [CNT_WD-1:0] br_cnt,
    output logic [CNT_WD-1:0] mispred_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        FLUSH
    } state_e;

    localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

    state_e            state_q;
    logic [2:0]        fc_q;
    logic [31:0]       redirect_pc_q;
    logic              redirect_valid_q;
    logic              flush_q;
    logic [CNT_WD-1:0] br_cnt_q;
    logic [CNT_WD-1:0] mispred_cnt_q;

    logic rdy;
    logic br_in_id;
    logic br_fire;
    logic br_mispred;

    assign rdy = (!id_need_src1 || src_1_ready) &&
                 (!id_need_src2 || src_2_ready);

    assign br_in_id   = (state_q == IDLE) && id_valid && id_is_branch;
    assign br_fire    = br_in_id && rdy && ex_allowin;
    assign br_mispred = br_fire && bu_cancel;

    // Outputs are forced low while reset is held so nothing leaks out of ID.
    always_comb begin
        id_stall       = 1'b0;
        id_to_ex_valid = 1'b0;
        if (resetn && (state_q == IDLE) && id_valid) begin
            if (id_is_branch) begin
                id_stall       = !(rdy && ex_allowin);
                id_to_ex_valid = rdy && ex_allowin;
            end else begin
                id_to_ex_valid = ex_allowin;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            fc_q             <= 3'd0;
            redirect_pc_q    <= 32'd0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            br_cnt_q         <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            if (br_fire && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_WD'(1);
            end
            if (br_mispred && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_WD'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (br_mispred) begin
                        state_q          <= REDIR;
                        redirect_pc_q    <= bu_next_pc;
                        redirect_valid_q <= 1'b1;
                        flush_q          <= 1'b1;
                    end
                end
                REDIR: begin
                    if (fetch_ready) begin
                        state_q          <= FLUSH;
                        fc_q             <= FC_INIT;
                        redirect_valid_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (fc_q == 3'd0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fc_q <= fc_q - 3'd1;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if       = flush_q;
    assign br_cnt         = br_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: vector table with scoreboard queue plus
// hand-written redirect, stall, reset and saturation sequences.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_is_branch, id_need_src1, id_need_src2;
    logic        src_1_ready, src_2_ready, bu_cancel, ex_allowin, fetch_ready;
    logic [31:0] bu_next_pc;

    logic        a_stall, a_fire, a_rv, a_flush;
    logic [31:0] a_pc;
    logic [31:0] a_br, a_mp;
    logic        b_stall, b_fire, b_rv, b_flush;
    logic [31:0] b_pc;
    logic [3:0]  b_br, b_mp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.FLUSH_CYCLES(1), .CNT_WD(32)) dut_a (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_need_src1(id_need_src1), .id_need_src2(id_need_src2),
        .src_1_ready(src_1_ready), .src_2_ready(src_2_ready),
        .bu_next_pc(bu_next_pc), .bu_cancel(bu_cancel),
        .ex_allowin(ex_allowin), .fetch_ready(fetch_ready),
        .id_stall(a_stall), .id_to_ex_valid(a_fire),
        .redirect_valid(a_rv), .redirect_pc(a_pc), .flush_if(a_flush),
        .br_cnt(a_br), .mispred_cnt(a_mp)
    );

    branch_resolve_ctrl #(.FLUSH_CYCLES(3), .CNT_WD(4)) dut_b (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_need_src1(id_need_src1), .id_need_src2(id_need_src2),
        .src_1_ready(src_1_ready), .src_2_ready(src_2_ready),
        .bu_next_pc(bu_next_pc), .bu_cancel(bu_cancel),
        .ex_allowin(ex_allowin), .fetch_ready(fetch_ready),
        .id_stall(b_stall), .id_to_ex_valid(b_fire),
        .redirect_valid(b_rv), .redirect_pc(b_pc), .flush_if(b_flush),
        .br_cnt(b_br), .mispred_cnt(b_mp)
    );

    typedef struct {
        logic v, br, n1, n2, r1, r2, al, ca;
        logic stall, fire;
    } vec_t;

    typedef struct {
        int          idx;
        logic        stall;
        logic        fire;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, br, n1, n2, r1, r2, al, ca, fr,
                         input logic [31:0] npc);
        @(posedge clk);
        #1;
        id_valid     = v;
        id_is_branch = br;
        id_need_src1 = n1;
        id_need_src2 = n2;
        src_1_ready  = r1;
        src_2_ready  = r2;
        ex_allowin   = al;
        bu_cancel    = ca;
        fetch_ready  = fr;
        bu_next_pc   = npc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        id_valid = 0; id_is_branch = 0; id_need_src1 = 0; id_need_src2 = 0;
        src_1_ready = 0; src_2_ready = 0; ex_allowin = 0; bu_cancel = 0;
        fetch_ready = 0; bu_next_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t tbl[10];
    exp_t e;
    logic [31:0] exp_br;

    initial begin
        // reset state with a stalling branch presented in ID
        resetn = 1'b0;
        id_valid = 1; id_is_branch = 1; id_need_src1 = 1; id_need_src2 = 0;
        src_1_ready = 0; src_2_ready = 0; ex_allowin = 1; bu_cancel = 1;
        fetch_ready = 0; bu_next_pc = 32'hdead_beef;
        #2;
        chk("rst_stall", a_stall, 0);
        chk("rst_fire", a_fire, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_br", a_br, 0);
        chk("rst_mp", a_mp, 0);
        chk("rst_b_rv", b_rv, 0);
        do_reset();

        //             v  br n1 n2 r1 r2 al ca  stall fire
        tbl[0] = '{v:0, br:0, n1:0, n2:0, r1:0, r2:0, al:1, ca:1, stall:0, fire:0};
        tbl[1] = '{v:1, br:0, n1:0, n2:0, r1:0, r2:0, al:1, ca:0, stall:0, fire:1};
        tbl[2] = '{v:1, br:0, n1:1, n2:1, r1:0, r2:0, al:0, ca:0, stall:0, fire:0};
        tbl[3] = '{v:1, br:1, n1:1, n2:1, r1:1, r2:1, al:1, ca:0, stall:0, fire:1};
        tbl[4] = '{v:1, br:1, n1:1, n2:1, r1:0, r2:1, al:1, ca:1, stall:1, fire:0};
        tbl[5] = '{v:1, br:1, n1:1, n2:1, r1:1, r2:0, al:1, ca:1, stall:1, fire:0};
        tbl[6] = '{v:1, br:1, n1:0, n2:0, r1:0, r2:0, al:1, ca:0, stall:0, fire:1};
        tbl[7] = '{v:1, br:1, n1:1, n2:1, r1:1, r2:1, al:0, ca:1, stall:1, fire:0};
        tbl[8] = '{v:1, br:1, n1:1, n2:0, r1:1, r2:0, al:1, ca:0, stall:0, fire:1};
        tbl[9] = '{v:1, br:1, n1:0, n2:1, r1:0, r2:0, al:1, ca:1, stall:1, fire:0};

        exp_br = 0;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].br, tbl[i].n1, tbl[i].n2, tbl[i].r1,
                  tbl[i].r2, tbl[i].al, tbl[i].ca, 0, $urandom);
            sbq.push_back('{idx: i, stall: tbl[i].stall,
                            fire: tbl[i].fire, cnt: exp_br});
            if (tbl[i].v && tbl[i].br && tbl[i].fire) exp_br++;
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("vec%0d_stall", e.idx), a_stall, e.stall);
            chk($sformatf("vec%0d_fire", e.idx), a_fire, e.fire);
            chk($sformatf("vec%0d_brcnt", e.idx), a_br, e.cnt);
            chk($sformatf("vec%0d_rv", e.idx), a_rv, 0);
        end
        idle();
        @(negedge clk);
        chk("vec_brcnt_end", a_br, exp_br);
        chk("vec_mpcnt_end", a_mp, 0);

        // mispredict, redirect held 3 cycles, then flush
        do_reset();
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0, 32'h1c00_0140);
        @(negedge clk);
        chk("mp_fire", a_fire, 1);
        chk("mp_rv_same", a_rv, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1, 1, 1, 1, 0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("redir%0d_rv", k), a_rv, 1);
            chk($sformatf("redir%0d_pc", k), a_pc, 32'h1c00_0140);
            chk($sformatf("redir%0d_flush", k), a_flush, 1);
            chk($sformatf("redir%0d_fire", k), a_fire, 0);
            chk($sformatf("redir%0d_stall", k), a_stall, 0);
            chk($sformatf("redir%0d_br", k), a_br, 1);
            chk($sformatf("redir%0d_mp", k), a_mp, 1);
            chk($sformatf("redir%0d_b_rv", k), b_rv, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        @(negedge clk);
        chk("accept_rv", a_rv, 1);
        chk("accept_flush", a_flush, 1);
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0, 32'h1c00_0999);
        @(negedge clk);
        chk("flush_rv", a_rv, 0);
        chk("flush_flush", a_flush, 1);
        chk("flush_fire", a_fire, 0);
        chk("flush_b1", b_flush, 1);
        idle();
        @(negedge clk);
        chk("post_flush", a_flush, 0);
        chk("post_br", a_br, 1);
        chk("post_mp", a_mp, 1);
        chk("flush_b2", b_flush, 1);
        idle();
        @(negedge clk);
        chk("flush_b3", b_flush, 1);
        idle();
        @(negedge clk);
        chk("flush_b4", b_flush, 0);
        chk("b_pc_held", b_pc, 32'h1c00_0140);

        // operand not ready for 2 cycles
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 1, 0, 1, 1, 1, 0, 32'h1c00_0200);
            @(negedge clk);
            chk($sformatf("opw%0d_stall", k), a_stall, 1);
            chk($sformatf("opw%0d_fire", k), a_fire, 0);
            chk($sformatf("opw%0d_rv", k), a_rv, 0);
            chk($sformatf("opw%0d_br", k), a_br, 0);
        end
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0, 32'h1c00_0200);
        @(negedge clk);
        chk("opw_fire", a_fire, 1);
        idle();
        @(negedge clk);
        chk("opw_rv", a_rv, 1);
        chk("opw_pc", a_pc, 32'h1c00_0200);
        chk("opw_mp", a_mp, 1);

        // jirl held by ex_allowin=0 for 4 cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 0, 1, 0, 0, 1, 0, 32'h1c00_0300);
            @(negedge clk);
            chk($sformatf("exw%0d_stall", k), a_stall, 1);
            chk($sformatf("exw%0d_rv", k), a_rv, 0);
            chk($sformatf("exw%0d_br", k), a_br, 0);
        end
        drive(1, 1, 1, 0, 1, 0, 1, 1, 0, 32'h1c00_0300);
        @(negedge clk);
        chk("exw_fire", a_fire, 1);
        chk("exw_rv0", a_rv, 0);
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 32'h0);
        @(negedge clk);
        chk("exw_rv1", a_rv, 1);
        chk("exw_pc", a_pc, 32'h1c00_0300);

        // async reset during REDIR
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 32'h0);
        #1 resetn = 1'b0;
        #1;
        chk("arst_rv", a_rv, 0);
        chk("arst_flush", a_flush, 0);
        chk("arst_br", a_br, 0);
        chk("arst_mp", a_mp, 0);
        chk("arst_pc", a_pc, 0);
        chk("arst_stall", a_stall, 0);
        chk("arst_b_rv", b_rv, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        @(negedge clk);
        chk("arel_rv", a_rv, 0);
        chk("arel_flush", a_flush, 0);
        drive(1, 1, 1, 1, 1, 1, 1, 0, 0, 32'h0);
        @(negedge clk);
        chk("arel_fire", a_fire, 1);
        idle();
        @(negedge clk);
        chk("arel_br", a_br, 1);
        chk("arel_rv2", a_rv, 0);

        // counter saturation on the 4-bit instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 1, 1, 1, 1, 1, 0, 0, 32'h0);
        end
        idle();
        @(negedge clk);
        chk("sat_a_br", a_br, 20);
        chk("sat_b_br", b_br, 15);
        chk("sat_b_mp", b_mp, 0);
        chk("sat_a_mp", a_mp, 0);
        chk("sat_rv", a_rv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
